uart_cmd_wrapper: RTL and testbench
===================================

Name: uart_cmd_wrapper

Overview:
- Serial front end of the QuadCopter. It receives 3-byte command frames (cmd, data high, data low) from the wireless link on RX and presents cmd/data with a cmd_rdy flag to cmd_cfg.
- It serializes the single-byte response (pos-ack 0xA5, etc.) from cmd_cfg back out on TX to the CommMaster.
- It contains its own 8N1 receiver and transmitter plus the frame-assembly state machine.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud).
- FRAME_TO, 262144, idle cycles between bytes of one frame before the partial frame is discarded.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial input, idle high, asynchronous to clk
- TX  out  1  serial output, idle high
- cmd  out  8  command byte of last complete frame
- data  out  16  data field of last complete frame, {byte2, byte3}
- cmd_rdy  out  1  complete frame available
- clr_cmd_rdy  in  1  consumer acknowledge; knocks down cmd_rdy
- resp  in  8  response byte to transmit
- send_resp  in  1  one-cycle strobe to start transmitting resp
- resp_sent  out  1  one-cycle pulse when the response stop bit has completed
- tx_busy  out  1  transmitter active

Behaviour:

Reset (async, rst_n low):
- TX=1, cmd=0, data=0, cmd_rdy=0, resp_sent=0, tx_busy=0.
- All FSMs go to IDLE. The RX synchronizer is preset to 1.

Receiver:
- RX passes through a 2-flop synchronizer, preset high.
- RX_IDLE: a synchronized 0 moves to START with the baud counter loaded to BAUD_DIV/2.
- START: at count 0, if RX is still 0, go to DATA; otherwise the start was a glitch, return to RX_IDLE.
- DATA: sample every BAUD_DIV cycles, LSB first, 8 bits.
- STOP: sample once more. If the stop bit is 1, pulse byte_rdy for one cycle with the byte. If it is 0, pulse frm_err and drop the byte.
- Return to RX_IDLE immediately after the stop sample. Back-to-back bytes with no idle gap are accepted.

Frame FSM:
- F_CMD: byte_rdy captures the byte into a cmd shadow register, then go to F_HI.
- F_HI: byte_rdy captures data_hi, then go to F_LO.
- F_LO: byte_rdy copies shadow cmd, data_hi and the byte into cmd/data in the same cycle. cmd_rdy=1 on the next edge. Return to F_CMD.
- cmd and data change only on frame completion; partial frames never disturb the outputs.
- frm_err in any state returns the FSM to F_CMD and discards the partial frame. cmd_rdy is unaffected.
- Inter-byte timeout: in F_HI or F_LO, an idle counter (cleared by any RX start detection) reaching FRAME_TO returns the FSM to F_CMD.

cmd_rdy:
- Set on frame completion.
- Cleared by clr_cmd_rdy, or when the first byte of a new frame is captured (F_CMD byte_rdy).
- If set and clear occur in the same cycle, set wins.

Latency:
- cmd_rdy rises exactly 2 + BAUD_DIV/2 + 9*BAUD_DIV + 2 cycles after the RX falling edge of byte 3's start bit.
- The 2 synchronizer cycles are included.

Transmitter:
- TX_IDLE: send_resp loads {1, resp, 0} into a 10-bit shift register, tx_busy=1, TX drives the start bit on the next edge.
- Each bit is held for exactly BAUD_DIV cycles.
- After the 10th bit period: resp_sent pulses for 1 cycle, tx_busy=0, TX=1.
- send_resp while tx_busy=1 is ignored; resp is not re-sampled mid-byte.
- send_resp in the same cycle resp_sent pulses is accepted.

Concurrency and width rules:
- RX and TX paths are fully independent (full duplex).
- All counters are unsigned. The baud counter is wide enough for BAUD_DIV: 12 bits at the default. The timeout counter is 18 bits.

Test Plan:
1. Send frame 0x05,0x01,0xFF -> cmd_rdy=1 with cmd=0x05, data=0x01FF. cmd_rdy rises 2+1302+23436+2 cycles after byte-3 start edge. Pulse clr_cmd_rdy -> cmd_rdy=0 next cycle.
2. Frame 0x04,0x00,0xFF followed immediately by 0x06,0x12,0x34, with no clr -> cmd_rdy drops when 0x06 is captured and re-asserts with cmd=0x06, data=0x1234. data stays 0x00FF until the second frame completes.
3. Send 0x05,0x01, idle for FRAME_TO+10 cycles, then 0x02,0xAA,0xBB -> exactly one cmd_rdy, with cmd=0x02, data=0xAABB.
4. Byte with stop bit forced to 0 mid-frame -> no cmd_rdy. The next clean 3-byte frame is received correctly. A 100-cycle RX low glitch -> no byte_rdy.
5. send_resp with resp=0xA5 -> TX shows 0,1,0,1,0,0,1,0,1,1 (LSB first), each bit 2604 cycles. resp_sent pulses once at cycle 26040. A second send_resp at cycle 5000 is ignored.
6. Assert rst_n low in the middle of RX byte 2 and TX bit 4 -> TX=1 and cmd_rdy=0 immediately. After release, a full frame 0x06,0x00,0x00 -> cmd=0x06, data=0x0000.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// Serial front end: 8N1 receiver, 3-byte command frame assembly (cmd, data_hi, data_lo)
// and a single-byte 8N1 response transmitter. RX and TX run fully independently.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604,
  parameter int FRAME_TO = 262144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam int BCW = $clog2(BAUD_DIV + 1);
  localparam int TOW = $clog2(FRAME_TO);
  localparam logic [BCW-1:0] BAUD_FULL = BCW'(BAUD_DIV);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(BAUD_DIV / 2);
  localparam logic [BCW-1:0] CNT_ONE   = BCW'(1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(FRAME_TO - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {F_CMD, F_HI, F_LO} frm_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  logic            rx_sync_p0, rx_sync_p1;
  rx_state_t       rx_state;
  logic [BCW-1:0]  rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_tick;
  logic            byte_rdy;
  logic            frm_err;
  logic            start_det;

  frm_state_t      f_state;
  logic [7:0]      cmd_shadow;
  logic [7:0]      hi_shadow;
  logic [TOW-1:0]  to_cnt;
  logic            to_hit;

  tx_state_t       tx_state;
  logic [BCW-1:0]  tx_cnt;
  logic [3:0]      tx_bit;
  logic [8:0]      tx_shift;
  logic            tx_tick;

  // Bit periods end when the down-counter reaches 1, so a load of N spans exactly N cycles.
  assign rx_tick   = (rx_cnt == CNT_ONE);
  assign tx_tick   = (tx_cnt == CNT_ONE);
  assign start_det = (rx_state == RX_IDLE) && !rx_sync_p1;
  assign to_hit    = (to_cnt == TO_LAST);

  // ---- stage p0/p1: RX synchronizer, preset to the idle level ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= RX;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  // ---- receiver control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
      if (rx_state != RX_IDLE && !rx_tick)
        rx_cnt <= rx_cnt - CNT_ONE;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync_p1) begin
            rx_state <= RX_START;
            rx_cnt   <= BAUD_HALF;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (!rx_sync_p1) begin
              rx_state <= RX_DATA;
              rx_cnt   <= BAUD_FULL;
              rx_bit   <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt <= BAUD_FULL;
            if (rx_bit == 3'd7)
              rx_state <= RX_STOP;
            else
              rx_bit <= rx_bit + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            byte_rdy <= rx_sync_p1;
            frm_err  <= !rx_sync_p1;
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Receiver data path: LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tick)
      rx_shift <= {rx_sync_p1, rx_shift[7:1]};
  end

  // ---- frame assembly ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state <= F_CMD;
      to_cnt  <= '0;
      cmd     <= '0;
      data    <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (clr_cmd_rdy)
        cmd_rdy <= 1'b0;
      if (f_state == F_CMD || start_det)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TOW'(1);
      if (frm_err) begin
        f_state <= F_CMD;
      end else if (byte_rdy) begin
        case (f_state)
          F_CMD: begin
            cmd_rdy <= 1'b0;
            f_state <= F_HI;
          end
          F_HI:  f_state <= F_LO;
          F_LO: begin
            cmd     <= cmd_shadow;
            data    <= {hi_shadow, rx_shift};
            cmd_rdy <= 1'b1;
            f_state <= F_CMD;
          end
          default: f_state <= F_CMD;
        endcase
      end else if (f_state != F_CMD && to_hit) begin
        f_state <= F_CMD;
      end
    end
  end

  // Shadow bytes only feed cmd/data on frame completion, so partial frames stay invisible.
  always_ff @(posedge clk) begin
    if (byte_rdy && f_state == F_CMD)
      cmd_shadow <= rx_shift;
    if (byte_rdy && f_state == F_HI)
      hi_shadow <= rx_shift;
  end

  // ---- transmitter control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      TX        <= 1'b1;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_state <= TX_SHIFT;
            tx_cnt   <= BAUD_FULL;
            tx_bit   <= '0;
            TX       <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        TX_SHIFT: begin
          if (tx_tick) begin
            if (tx_bit == 4'd9) begin
              tx_state  <= TX_IDLE;
              TX        <= 1'b1;
              tx_busy   <= 1'b0;
              resp_sent <= 1'b1;
            end else begin
              tx_cnt <= BAUD_FULL;
              tx_bit <= tx_bit + 4'd1;
              TX     <= tx_shift[0];
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Transmit data path: data bits then stop; the start bit is driven directly on load.
  always_ff @(posedge clk) begin
    if (tx_state == TX_IDLE && send_resp)
      tx_shift <= {1'b1, resp};
    else if (tx_state == TX_SHIFT && tx_tick)
      tx_shift <= {1'b1, tx_shift[8:1]};
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper with a shortened bit time and frame timeout.
module tb_uart_cmd_wrapper;
  localparam int B  = 64;
  localparam int TO = 2048;
  localparam int H  = B / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;

  int errors = 0;
  int checks = 0;
  int rdy_rises = 0;
  logic rdy_prev = 1'b0;

  uart_cmd_wrapper #(.BAUD_DIV(B), .FRAME_TO(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdy_prev <= cmd_rdy;
    if (cmd_rdy && !rdy_prev) rdy_rises <= rdy_rises + 1;
  end

  // Drives one 8N1 byte; call at a negedge, returns at the negedge ending the stop bit.
  task automatic rx_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = stop_bit;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RX = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", TX); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_cmd_rdy: got %b expected 0", cmd_rdy); end
    checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL rst_cmd: got %h expected 00", cmd); end
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h expected 0000", data); end
    checks++; if (resp_sent !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL rst_tx_flags: got sent=%b busy=%b expected 0 0", resp_sent, tx_busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame_latency();
    int lat;
    rx_byte(8'h05, 1'b1);
    rx_byte(8'h01, 1'b1);
    lat = 0;
    fork
      rx_byte(8'hFF, 1'b1);
      begin
        while (!cmd_rdy && lat < 12 * B) begin
          @(posedge clk); #1; lat++;
        end
      end
    join
    checks++; if (lat !== 2 + H + 9 * B + 2) begin errors++; $display("FAIL t1_latency: got %0d cycles expected %0d", lat, 2 + H + 9 * B + 2); end
    checks++; if (cmd !== 8'h05) begin errors++; $display("FAIL t1_cmd: got %h expected 05", cmd); end
    checks++; if (data !== 16'h01FF) begin errors++; $display("FAIL t1_data: got %h expected 01ff", data); end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL t1_clr: got %b expected 0", cmd_rdy); end
    checks++; if (cmd !== 8'h05) begin errors++; $display("FAIL t1_cmd_hold: got %h expected 05", cmd); end
  endtask

  task automatic test_back_to_back();
    rx_byte(8'h04, 1'b1); rx_byte(8'h00, 1'b1); rx_byte(8'hFF, 1'b1);
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h04 || data !== 16'h00FF) begin errors++; $display("FAIL t2_first: got rdy=%b cmd=%h data=%h expected 1 04 00ff", cmd_rdy, cmd, data); end
    rx_byte(8'h06, 1'b1);
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL t2_drop: got %b expected 0", cmd_rdy); end
    checks++; if (cmd !== 8'h04 || data !== 16'h00FF) begin errors++; $display("FAIL t2_hold1: got cmd=%h data=%h expected 04 00ff", cmd, data); end
    rx_byte(8'h12, 1'b1);
    checks++; if (cmd_rdy !== 1'b0 || data !== 16'h00FF) begin errors++; $display("FAIL t2_hold2: got rdy=%b data=%h expected 0 00ff", cmd_rdy, data); end
    rx_byte(8'h34, 1'b1);
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h06 || data !== 16'h1234) begin errors++; $display("FAIL t2_second: got rdy=%b cmd=%h data=%h expected 1 06 1234", cmd_rdy, cmd, data); end
  endtask

  task automatic test_timeout();
    int r0;
    r0 = rdy_rises;
    rx_byte(8'h05, 1'b1); rx_byte(8'h01, 1'b1);
    repeat (TO + 10) @(negedge clk);
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL t3_idle_rdy: got %b expected 0", cmd_rdy); end
    rx_byte(8'h02, 1'b1); rx_byte(8'hAA, 1'b1); rx_byte(8'hBB, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rdy_rises - r0 !== 1) begin errors++; $display("FAIL t3_rises: got %0d expected 1", rdy_rises - r0); end
    checks++; if (cmd !== 8'h02 || data !== 16'hAABB) begin errors++; $display("FAIL t3_frame: got cmd=%h data=%h expected 02 aabb", cmd, data); end
  endtask

  task automatic test_errors();
    int r0;
    r0 = rdy_rises;
    rx_byte(8'h05, 1'b1);
    rx_byte(8'h01, 1'b0);
    repeat (2 * B) @(negedge clk);
    checks++; if (cmd_rdy !== 1'b0 || rdy_rises !== r0) begin errors++; $display("FAIL t4_frm_err: got rdy=%b rises=%0d expected 0 %0d", cmd_rdy, rdy_rises, r0); end
    RX = 1'b0;
    repeat (10) @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    rx_byte(8'h03, 1'b1); rx_byte(8'h12, 1'b1); rx_byte(8'h34, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rdy_rises - r0 !== 1) begin errors++; $display("FAIL t4_rises: got %0d expected 1", rdy_rises - r0); end
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h03 || data !== 16'h1234) begin errors++; $display("FAIL t4_frame: got rdy=%b cmd=%h data=%h expected 1 03 1234", cmd_rdy, cmd, data); end
  endtask

  task automatic test_tx();
    logic [9:0] tx_exp;
    int sent_cnt, sent_at, idx;
    tx_exp = {1'b1, 8'hA5, 1'b0};
    sent_cnt = 0; sent_at = 0;
    resp = 8'hA5; send_resp = 1'b1;
    for (int c = 1; c <= 10 * B + 3; c++) begin
      @(negedge clk);
      if (resp_sent) begin sent_cnt++; sent_at = c; end
      if ((c - 1) % B == H) begin
        idx = (c - 1) / B;
        checks++; if (TX !== tx_exp[idx]) begin errors++; $display("FAIL t5_bit%0d: got %b expected %b", idx, TX, tx_exp[idx]); end
      end
      if (c == 1) begin
        send_resp = 1'b0;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL t5_busy: got %b expected 1", tx_busy); end
      end
      if (c == 2 * B + 5) begin resp = 8'h3C; send_resp = 1'b1; end
      if (c == 2 * B + 6) send_resp = 1'b0;
      if (c == 10 * B + 1) begin resp = 8'h5A; send_resp = 1'b1; end
      if (c == 10 * B + 2) begin
        send_resp = 1'b0;
        checks++; if (TX !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL t5_accept_on_sent: got tx=%b busy=%b expected 0 1", TX, tx_busy); end
      end
    end
    checks++; if (sent_cnt !== 1 || sent_at !== 10 * B + 1) begin errors++; $display("FAIL t5_resp_sent: got count=%0d at=%0d expected 1 at %0d", sent_cnt, sent_at, 10 * B + 1); end
    repeat (11 * B) @(negedge clk);
    checks++; if (TX !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL t5_idle: got tx=%b busy=%b expected 1 0", TX, tx_busy); end
  endtask

  task automatic test_reset_midstream();
    fork
      begin
        rx_byte(8'h07, 1'b1);
        rx_byte(8'h08, 1'b1);
      end
      begin
        repeat (10 * B + H) @(negedge clk);
        resp = 8'h00; send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (4 * B + H - 1) @(negedge clk);
        checks++; if (TX !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL t6_pre: got tx=%b busy=%b expected 0 1", TX, tx_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (TX !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL t6_rst_tx: got tx=%b busy=%b expected 1 0", TX, tx_busy); end
        checks++; if (cmd_rdy !== 1'b0 || cmd !== 8'h00 || data !== 16'h0000) begin errors++; $display("FAIL t6_rst_rx: got rdy=%b cmd=%h data=%h expected 0 00 0000", cmd_rdy, cmd, data); end
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL t6_tx_idle: got %b expected 1", TX); end
    rx_byte(8'h06, 1'b1); rx_byte(8'h00, 1'b1); rx_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h06 || data !== 16'h0000) begin errors++; $display("FAIL t6_frame: got rdy=%b cmd=%h data=%h expected 1 06 0000", cmd_rdy, cmd, data); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame_latency();
    test_back_to_back();
    test_timeout();
    test_errors();
    test_tx();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
